id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the 32-bit core, placed directly downstream of the register file. It captures the two register-file read operands and decode control, applies a writeback-to-decode bypass, and detects load-use hazards. The bypass is required because the register file writes on the clock edge and reads combinationally without internal forwarding. It presents a valid/ready handshake to the execute stage and inserts bubbles or holds as required.

## Interface
Parameters:
- `XLEN`, 32, operand/immediate width
- `CTRL_W`, 16, width of opaque execute control bundle

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  kill EX-held and incoming instruction
- `id_valid`  in  1  decode presents an instruction
- `id_ready`  out  1  stage accepts decode this cycle (combinational)
- `id_rs1`, `id_rs2`  in  5  source register indices
- `id_use_rs1`, `id_use_rs2`  in  1  source actually read
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data
- `id_rd`  in  5  destination index
- `id_reg_write`  in  1  instruction writes `id_rd`
- `id_mem_read`  in  1  instruction is a load
- `id_imm`  in  XLEN  immediate
- `id_ctrl`  in  CTRL_W  execute control
- `wb_reg_write`  in  1  writeback writes this cycle
- `wb_rd`  in  5  writeback index
- `wb_data`  in  XLEN  writeback data
- `ex_valid`  out  1  EX entry valid
- `ex_ready`  in  1  execute consumes entry
- `ex_rs1_data`, `ex_rs2_data`  out  XLEN  captured operands
- `ex_rd`  out  5; `ex_reg_write` out 1; `ex_mem_read` out 1; `ex_imm` out XLEN; `ex_ctrl` out CTRL_W
- `perf_stall_cnt`  out  32  load-use bubble count (only with macro, see Configuration)

## Operation
- Hazard: `hz = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
- `id_ready = flush | (!hz & (!ex_valid | ex_ready))`.
- Bypass at capture: operand N = `wb_data` if `wb_reg_write & wb_rd!=0 & wb_rd==id_rsN`, else `id_rsN_data`. Index 0 is never bypassed.
- Edge actions, in priority order:
  - `flush`: `ex_valid<=0`; incoming instruction dropped.
  - `id_valid & id_ready`: capture all fields, `ex_valid<=1`, `ex_reg_write<=id_reg_write & id_rd!=0`.
  - `ex_valid & ex_ready` (no capture, including `hz`): `ex_valid<=0`, i.e. a bubble.
  - Otherwise hold every output unchanged.
- Payload registers update only on capture. Contents with `ex_valid=0` are don't-care except after reset.

## Timing
- Reset: `ex_valid=0`; all data/control outputs 0; `perf_stall_cnt=0`; `id_ready=1`.
- Latency 1 cycle: fields accepted at edge N appear at outputs after edge N.
- Load-use costs exactly one bubble when `ex_ready=1`. With `ex_ready=0`, hold; the stall lasts until the load leaves.
- Simultaneous `wb` write and capture of the same index: captured value is `wb_data`.
- Same index on both sources: both operands are bypassed.
- `flush` together with `hz` or `ex_ready=0`: `flush` wins, `ex_valid=0` next cycle.
- `rst` mid-hold: clears immediately (asynchronously), no output glitch beyond the reset values.

## Configuration
- Macro `ID_EX_STALL_CNT_EN`:
  - Defined: `perf_stall_cnt` increments by 1 on every edge where `hz & ex_ready & !flush`. It wraps at 2^32 and resets to 0.
  - Undefined: the port is absent and no counter logic exists.

## Test plan
- Reset then idle: `ex_valid=0`, `id_ready=1`, all outputs 0.
- Capture `id_rs1_data=0x11`, `id_rs2_data=0x22`, `id_rd=5`, `ex_ready=1` → next cycle `ex_valid=1` with the same values, `ex_reg_write=1`.
- WB bypass: `wb_rd=3`, `wb_data=0xDEAD`, `id_rs1=id_rs2=3`, stale read 0 → both EX operands 0xDEAD. Repeat with `wb_rd=0` → operands 0.
- Load-use: EX holds a load with `rd=7`; decode `id_rs2=7`, `id_use_rs2=1` → `id_ready=0`, one bubble (`ex_valid=0`), then capture next cycle; `perf_stall_cnt=1`.
- Back-pressure: `ex_ready=0` for 3 cycles → outputs stable and `id_ready=0`; release → next instruction accepted.
- `flush` with valid entry and `ex_ready=0` → `ex_valid=0` next cycle, incoming instruction discarded.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with writeback bypass and load-use hazard detection.
// Optional load-use stall counter is enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // The register file does not forward its own write, so a same-cycle writeback must be picked up here.
    function automatic logic [XLEN-1:0] bypass(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic            wr_en,
        input logic [4:0]      wr_idx,
        input logic [XLEN-1:0] wr_data
    );
        if (wr_en && (wr_idx != 5'd0) && (wr_idx == rs)) begin
            return wr_data;
        end
        return rf_data;
    endfunction

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic hz;
    logic src_match;
    logic capture;

    assign src_match = (id_use_rs1 && (id_rs1 == rd_q)) || (id_use_rs2 && (id_rs2 == rd_q));
    assign hz        = valid_q && mem_read_q && (rd_q != 5'd0) && id_valid && src_match;
    assign id_ready  = flush || (!hz && (!valid_q || ex_ready));
    assign capture   = !flush && id_valid && id_ready;

    always_comb begin
        valid_d     = valid_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d     = 1'b1;
            rs1_data_d  = bypass(id_rs1, id_rs1_data, wb_reg_write, wb_rd, wb_data);
            rs2_data_d  = bypass(id_rs2, id_rs2_data, wb_reg_write, wb_rd, wb_data);
            rd_d        = id_rd;
            reg_write_d = id_reg_write && (id_rd != 5'd0);
            mem_read_d  = id_mem_read;
            imm_d       = id_imm;
            ctrl_d      = id_ctrl;
        end else if (valid_q && ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            imm_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;

`ifdef ID_EX_STALL_CNT_EN
    // Counts only bubbles actually injected: a stalled load that is not draining costs no bubble yet.
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz && ex_ready && !flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by randomized traffic
// compared against a behavioural model of the stage.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst, flush, id_valid, id_ready;
    logic [4:0]        id_rs1, id_rs2, id_rd, wb_rd, ex_rd;
    logic              id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, wb_reg_write;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [CTRL_W-1:0] id_ctrl, ex_ctrl;
    logic              ex_valid, ex_ready, ex_reg_write, ex_mem_read;
    logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data, ex_imm;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]       perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state: the entry EX should be holding
    bit              m_valid;
    bit [XLEN-1:0]   m_rs1, m_rs2, m_imm;
    bit [4:0]        m_rd;
    bit              m_rw, m_mr;
    bit [CTRL_W-1:0] m_ctrl;
    bit [31:0]       m_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_STALL_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [XLEN-1:0] exp_operand(input bit [4:0] rs, input bit [XLEN-1:0] rf);
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic bit model_hazard();
        bit reads_rd;
        reads_rd = (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
        return m_valid && m_mr && m_rd != 0 && id_valid && reads_rd;
    endfunction

    function automatic bit model_ready();
        return flush || (!model_hazard() && (!m_valid || ex_ready));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
        m_rw = 0; m_mr = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ex_valid"}, ex_valid, m_valid);
        chk({tag, ".rs1"}, ex_rs1_data, m_rs1);
        chk({tag, ".rs2"}, ex_rs2_data, m_rs2);
        chk({tag, ".rd"}, ex_rd, m_rd);
        chk({tag, ".reg_write"}, ex_reg_write, m_rw);
        chk({tag, ".mem_read"}, ex_mem_read, m_mr);
        chk({tag, ".imm"}, ex_imm, m_imm);
        chk({tag, ".ctrl"}, ex_ctrl, m_ctrl);
`ifdef ID_EX_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, perf_stall_cnt, m_cnt);
`endif
    endtask

    // one clock: inputs are already driven; check id_ready, advance model and DUT, check outputs
    task automatic step(input string tag);
        bit hz, rdy;
        #1;
        hz  = model_hazard();
        rdy = model_ready();
        chk({tag, ".id_ready"}, id_ready, rdy);
        if (hz && ex_ready && !flush) m_cnt++;
        if (flush) begin
            m_valid = 0;
        end else if (id_valid && rdy) begin
            m_valid = 1;
            m_rs1   = exp_operand(id_rs1, id_rs1_data);
            m_rs2   = exp_operand(id_rs2, id_rs2_data);
            m_rd    = id_rd;
            m_rw    = id_reg_write && id_rd != 0;
            m_mr    = id_mem_read;
            m_imm   = id_imm;
            m_ctrl  = id_ctrl;
        end else if (m_valid && ex_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
        id_imm = 0; id_ctrl = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
    endtask

    task automatic random_inputs();
        flush        = ($urandom_range(15) == 0);
        id_valid     = ($urandom_range(3) != 0);
        id_rs1       = 5'($urandom_range(3));
        id_rs2       = 5'($urandom_range(3));
        id_use_rs1   = 1'($urandom);
        id_use_rs2   = 1'($urandom);
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_rd        = 5'($urandom_range(3));
        id_reg_write = 1'($urandom);
        id_mem_read  = ($urandom_range(2) == 0);
        id_imm       = $urandom;
        id_ctrl      = 16'($urandom);
        wb_reg_write = 1'($urandom);
        wb_rd        = 5'($urandom_range(3));
        wb_data      = $urandom;
        ex_ready     = ($urandom_range(3) != 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.id_ready", id_ready, 1);
        rst = 0;
        step("idle");

        // plain capture
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
        id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_rd = 5; id_reg_write = 1;
        id_imm = 32'h1234; id_ctrl = 16'hA5A5;
        step("capture");
        chk("capture.valid_const", ex_valid, 1);
        chk("capture.rs1_const", ex_rs1_data, 32'h11);
        chk("capture.rs2_const", ex_rs2_data, 32'h22);
        chk("capture.rw_const", ex_reg_write, 1);

        // writeback bypass on both sources, then index 0 must not bypass
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'hDEAD;
        id_rs1 = 3; id_rs2 = 3; id_rs1_data = 0; id_rs2_data = 0;
        step("bypass");
        chk("bypass.rs1_const", ex_rs1_data, 32'hDEAD);
        chk("bypass.rs2_const", ex_rs2_data, 32'hDEAD);
        wb_rd = 0; id_rs1 = 0; id_rs2 = 0;
        step("bypass0");
        chk("bypass0.rs1_const", ex_rs1_data, 0);
        chk("bypass0.rs2_const", ex_rs2_data, 0);

        // load-use: load to x7 in EX, consumer reads x7 via rs2
        wb_reg_write = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
        step("load");
        id_rs2 = 7; id_use_rs2 = 1; id_mem_read = 0; id_rd = 8; id_rs2_data = 32'h77;
        #1;
        chk("loaduse.id_ready_const", id_ready, 0);
        step("bubble");
        chk("bubble.valid_const", ex_valid, 0);
        step("after_bubble");
        chk("after_bubble.valid_const", ex_valid, 1);
        chk("after_bubble.rd_const", ex_rd, 8);
`ifdef ID_EX_STALL_CNT_EN
        chk("loaduse.cnt_const", perf_stall_cnt, 1);
`endif

        // back-pressure for three cycles, then release
        ex_ready = 0; id_rd = 9; id_imm = 32'h9999; id_use_rs2 = 0;
        for (int i = 0; i < 3; i++) begin
            step("hold");
            chk("hold.rd_const", ex_rd, 8);
            chk("hold.id_ready_const", id_ready, 0);
        end
        ex_ready = 1;
        step("release");
        chk("release.rd_const", ex_rd, 9);

        // flush beats back-pressure and discards the incoming instruction
        ex_ready = 0; flush = 1; id_rd = 10;
        step("flush");
        chk("flush.valid_const", ex_valid, 0);
        flush = 0; id_valid = 0;
        step("post_flush");
        chk("post_flush.valid_const", ex_valid, 0);

        for (int i = 0; i < 400; i++) begin
            random_inputs();
            step("rand");
        end

        // asynchronous reset while an entry is held
        idle_inputs();
        id_valid = 1; id_rd = 4; id_reg_write = 1; id_rs1_data = 32'h55;
        step("pre_areset");
        ex_ready = 0; id_valid = 0;
        step("hold_areset");
        #2;
        rst = 1;
        #1;
        model_reset();
        check_outputs("areset");
        chk("areset.id_ready", id_ready, 1);
        @(posedge clk);
        #1;
        rst = 0;
        check_outputs("areset_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
